// File: rtl/fifo_thr.sv
// Synchronous FIFO with level-threshold flags and sticky overflow/underflow errors.
// Define FIFO_THR_FWFT_EN to build first-word fall-through read behaviour.
module fifo_thr #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_THR  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              wr_en,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_ready,
  input  logic                              rd_en,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_val,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic                              overflow,
  output logic                              underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THR);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THR);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    wr_ready = (level_q < DEPTH_L);
    // Flush wins over any same-cycle request.
    wr_acc   = wr_en && wr_ready && !flush;
    rd_acc   = rd_en && (level_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (wr_en && !wr_ready);
    unf_d    = unf_q | (rd_en && (level_q == '0));
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_THR_FWFT_EN
  // Head word is shown directly; gated to zero while empty so reset reads 0.
  always_comb begin
    rd_val  = (level_q != '0);
    rd_data = rd_val ? mem_q[rd_ptr_q] : '0;
  end
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_val_q, rd_val_d;

  always_comb begin
    rd_val_d  = rd_acc;
    rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
      rd_val_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_val_q  <= rd_val_d;
    end
  end

  always_comb begin
    rd_val  = rd_val_q;
    rd_data = rd_data_q;
  end
`endif

  always_comb begin
    level        = level_q;
    almost_full  = (level_q >= AFULL_L);
    almost_empty = (level_q <= AEMPTY_L);
    overflow     = ovf_q;
    underflow    = unf_q;
  end

endmodule

// File: doc/fifo_thr.md
FIFO_THR -- requirements
Module: fifo_thr

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of storage words (any integer >= 2, not only powers of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per word.
REQ-003 SHALL have parameter AFULL_THR, default FIFO_DEPTH-2, almost-full level threshold.
REQ-004 SHALL have parameter AEMPTY_THR, default 2, almost-empty level threshold.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port flush  input  1  synchronous clear of contents and error flags.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write word.
REQ-010 SHALL have port wr_ready  output  1  FIFO can accept a word this cycle.
REQ-011 SHALL have port rd_en  input  1  read request / pop.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  read word.
REQ-013 SHALL have port rd_val  output  1  rd_data valid.
REQ-014 SHALL have port level  output  $clog2(FIFO_DEPTH+1)  number of stored words.
REQ-015 SHALL have ports almost_full, almost_empty  output  1 each  threshold flags.
REQ-016 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 SHALL store words in a circular buffer with write and read pointers of width $clog2(FIFO_DEPTH), each wrapping from FIFO_DEPTH-1 to 0.
REQ-018 SHALL drive wr_ready = (level < FIFO_DEPTH), decoded from registered state only, with no combinational path from wr_en or rd_en.
REQ-019 SHALL accept a write only when wr_en && wr_ready: wr_data stored at write pointer, pointer advances.
REQ-020 SHALL accept a read only when rd_en && level > 0: read pointer advances.
REQ-021 SHALL update level: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-022 SHALL, when full with wr_en && rd_en, accept the read and reject the write (wr_ready=0 that cycle); when empty with both, accept the write and reject the read.
REQ-023 SHALL set overflow when wr_en && !wr_ready, and underflow when rd_en && level == 0; both stay set until flush or reset.
REQ-024 SHALL drive almost_full = (level >= AFULL_THR) and almost_empty = (level <= AEMPTY_THR), decoded from registered level.
REQ-025 SHALL, on flush, set level and both pointers to 0, clear rd_val, overflow and underflow, and ignore same-cycle wr_en/rd_en; storage contents are not cleared.
REQ-026 SHALL keep rd_data unchanged when no read is accepted.

Reset
REQ-027 SHALL, while reset=0, immediately force level=0, pointers=0, rd_val=0, rd_data=0, overflow=0, underflow=0, hence wr_ready=1, almost_empty=1, almost_full=0.
REQ-028 SHALL not reset the storage array.
REQ-029 SHALL, on reset assertion mid-transfer, discard all stored words and the in-flight read; first accepted write after release lands at address 0.

Configuration
REQ-030 SHALL compile first-word fall-through mode when macro FIFO_THR_FWFT_EN is defined.
REQ-031 SHALL, without FIFO_THR_FWFT_EN, present the word one cycle after an accepted read: rd_data = popped word and rd_val=1 for exactly one cycle; otherwise rd_val=0.
REQ-032 SHALL, with FIFO_THR_FWFT_EN, hold rd_val=1 whenever level > 0, with rd_data = word at read pointer; rd_en while rd_val=1 pops it, and the next word (or rd_val=0) appears the following cycle.
REQ-033 SHALL, with FIFO_THR_FWFT_EN, show a word written into an empty FIFO on rd_data with rd_val=1 in the cycle after the write.

Verification
REQ-034 SHALL cover fill/drain, DEPTH=5: write 0x11..0x15 -> level 5, wr_ready=0, almost_full=1; 5 reads -> 0x11..0x15 in order, level 0.
REQ-035 SHALL cover wrap-around, DEPTH=5: write 3, read 3, write 0x21..0x25 -> reads return 0x21..0x25 in order, no error flags.
REQ-036 SHALL cover simultaneous access: full with wr_en=rd_en=1 -> level 4, overflow=1; empty with both -> level 1, underflow=1, rd_val=0.
REQ-037 SHALL cover flush: 3 words stored, flush=1 with wr_en=1 -> next cycle level 0, flags 0, following read gives rd_val=0.
REQ-038 SHALL cover async reset: reset=0 between clock edges with 4 words stored -> level 0, rd_val 0, wr_ready 1 before the next edge.
REQ-039 SHALL cover FWFT (FIFO_THR_FWFT_EN defined): write 0xA5 into empty -> next cycle rd_val=1, rd_data=0xA5 with no rd_en; rd_en=1 -> next cycle rd_val=0.
